program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 4, program-memory address width (depth 2**ADDR_W entries of 3-bit instructions).
REQ-002 Parameter: TIMEOUT, default 15, max WAIT cycles allowed without core completion.
REQ-003 Clocking: the block SHALL use one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_load_en  input  1  program-memory write strobe.
REQ-007 i_load_addr  input  ADDR_W  write address.
REQ-008 i_load_instr  input  3  instruction word to write.
REQ-009 i_run  input  1  start-execution request, level sampled each cycle.
REQ-010 i_last_addr  input  ADDR_W  address of final program instruction, sampled on accepted i_run.
REQ-011 i_con_pcincr  input  1  core completion pulse (instruction finished).
REQ-012 o_data_instruction  output  3  instruction presented to the core.
REQ-013 o_start  output  1  one-cycle instruction-start pulse to the core.
REQ-014 o_pc  output  ADDR_W  current program counter.
REQ-015 o_busy  output  1  high in ISSUE or WAIT.
REQ-016 o_halt  output  1  high in DONE.
REQ-017 o_error  output  1  high in ERROR.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT, DONE, ERROR; all outputs registered or decoded from registered state only.
REQ-019 Memory write SHALL occur on i_load_en=1 only when state is IDLE, DONE or ERROR; writes during ISSUE/WAIT SHALL be dropped.
REQ-020 IDLE/DONE/ERROR with i_run=1 SHALL set pc=0, latch i_last_addr, clear o_halt/o_error, go to ISSUE next cycle.
REQ-021 i_run while busy SHALL be ignored; i_run and i_load_en in the same cycle: write performed, then run accepted (run fetches updated contents).
REQ-022 ISSUE SHALL last exactly one cycle: o_start=1, o_data_instruction=mem[pc], wait timer cleared to 0, next state WAIT.
REQ-023 WAIT SHALL hold o_data_instruction=mem[pc], o_start=0, timer incrementing by 1 per cycle.
REQ-024 WAIT with i_con_pcincr=1 and pc!=latched last_addr SHALL increment pc and enter ISSUE (o_start one cycle after the pcincr cycle).
REQ-025 WAIT with i_con_pcincr=1 and pc==latched last_addr SHALL enter DONE, pc unchanged; pc SHALL never wrap.
REQ-026 WAIT with no pcincr for TIMEOUT consecutive cycles SHALL enter ERROR; pcincr in the same cycle the timer reaches TIMEOUT SHALL win.
REQ-027 i_con_pcincr outside WAIT (including the ISSUE cycle) SHALL be ignored.
REQ-028 DONE and ERROR SHALL hold pc and o_data_instruction until reset or accepted i_run.
REQ-029 Latency: accepted i_run in cycle n -> o_start in cycle n+1; program of k instructions with immediate completions -> o_halt rises 2k+1 cycles after run accepted.

Reset
REQ-030 i_rst=1 SHALL force state IDLE, pc=0, timer=0, latched last_addr=0, o_start=0, o_busy=0, o_halt=0, o_error=0, o_data_instruction=0, overriding all other inputs incl. mid-program.
REQ-031 Program memory contents SHALL be unaffected by reset.

Verification
REQ-032 Load mem[0..2]=3'b001,3'b010,3'b011, run with last_addr=2, pcincr 3 cycles after each o_start -> three o_start pulses with instructions 1,2,3, pc 0->1->2, o_halt=1, o_busy=0.
REQ-033 Run last_addr=0, never assert pcincr -> o_error=1 after 15 WAIT cycles, o_busy=0; new i_run -> o_error=0, o_start next cycle.
REQ-034 pcincr asserted exactly on 15th WAIT cycle -> no ERROR, next instruction issued.
REQ-035 Load attempt to addr 5 during WAIT, later read via program reaching addr 5 -> original contents, not dropped write value.
REQ-036 Assert i_rst during WAIT at pc=3 -> next cycle state IDLE, all outputs 0, memory intact for following run.
REQ-037 last_addr=15, all 16 entries issued -> DONE at pc=15, no wrap to 0, no 17th o_start.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer
//   Small instruction sequencer. A 3-bit program is loaded into an internal
//   memory while the sequencer is not executing. An i_run request issues the
//   instructions mem[0] .. mem[last_addr] one at a time to an external core.
//   Each instruction is presented with a one-cycle o_start pulse. The
//   sequencer then waits for the core's completion pulse before it issues the
//   next one. A core that stays silent for TIMEOUT wait cycles drives the
//   sequencer into an error state.
//
// Ports
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_load_en/_addr/_instr  program-memory write port (ignored while busy)
//   i_run, i_last_addr  start request and index of the final instruction
//   i_con_pcincr        core completion pulse
//   o_data_instruction  instruction presented to the core (registered)
//   o_start             one-cycle issue pulse
//   o_pc                current program counter
//   o_busy/o_halt/o_error  status decoded from the state register
module program_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [2:0]        i_load_instr,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_last_addr,
  input  logic              i_con_pcincr,
  output logic [2:0]        o_data_instruction,
  output logic              o_start,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_busy,
  output logic              o_halt,
  output logic              o_error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [2:0]        instr_q;

  logic [2:0]        mem [DEPTH];
  logic              wr_en;
  logic              rd_en;
  logic              rd_bypass;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    last_d    = last_q;
    timer_d   = timer_q;
    rd_en     = 1'b0;
    // The program can only be changed while the sequencer is not executing.
    wr_en     = i_load_en && (state_q inside {S_IDLE, S_DONE, S_ERROR});

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_run) begin
          state_d = S_ISSUE;
          pc_d    = '0;
          last_d  = i_last_addr;
          rd_en   = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        // A completion on the final wait cycle takes priority over the timeout.
        if (i_con_pcincr) begin
          if (pc_q == last_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            pc_d    = pc_q + 1'b1;
            rd_en   = 1'b1;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th silent wait cycle.
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A write and a run in the same cycle: the fetch sees the new word.
    rd_bypass = wr_en && (i_load_addr == pc_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // Program memory has no reset so that the program survives i_rst.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[i_load_addr] <= i_load_instr;
    end
  end

  // Registered read. The word is fetched only when an instruction is about to
  // be issued, so it stays stable through WAIT, DONE and ERROR.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q <= '0;
    end else if (rd_en) begin
      instr_q <= rd_bypass ? i_load_instr : mem[pc_d];
    end
  end

  assign o_data_instruction = instr_q;
  assign o_pc               = pc_q;
  assign o_start            = (state_q == S_ISSUE);
  assign o_busy             = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign o_halt             = (state_q == S_DONE);
  assign o_error            = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed and randomized checks of program_sequencer against a
// program-level model. The model holds the expected memory contents and the
// expected issue order of each run.
module tb_program_sequencer;

  localparam int AW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [2:0]    load_instr;
  logic          run;
  logic [AW-1:0] last_addr;
  logic          pcincr;
  logic [2:0]    data;
  logic          start;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halt;
  logic          err;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] mem_m [16];

  program_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_load_en          (load_en),
    .i_load_addr        (load_addr),
    .i_load_instr       (load_instr),
    .i_run              (run),
    .i_last_addr        (last_addr),
    .i_con_pcincr       (pcincr),
    .o_data_instruction (data),
    .o_start            (start),
    .o_pc               (pc),
    .o_busy             (busy),
    .o_halt             (halt),
    .o_error            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and then return strobes to their idle values.
  task automatic tick();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_instr = '0;
    run        = 1'b0;
    pcincr     = 1'b0;
  endtask

  task automatic load_mem(input int addr, input logic [2:0] v);
    load_en    = 1'b1;
    load_addr  = addr[AW-1:0];
    load_instr = v;
    mem_m[addr] = v;
    tick();
  endtask

  // Runs a program from mem[0] to mem[last].
  //   fixed_delay: the wait cycle on which the core completes (0 = random,
  //                a value above TO = the core never completes).
  //   drop_addr:   a write to this address is attempted while busy.
  //   rst_pc:      reset is asserted on the first wait cycle of this pc.
  //   load_with_run: mem[0] is rewritten in the same cycle as the run.
  task automatic run_prog(input int last, input int fixed_delay, input int drop_addr,
                          input int rst_pc, input bit load_with_run);
    int d;
    logic [2:0] v;
    run       = 1'b1;
    last_addr = last[AW-1:0];
    if (load_with_run) begin
      v          = 3'($urandom);
      load_en    = 1'b1;
      load_addr  = '0;
      load_instr = v;
      mem_m[0]   = v;
    end
    tick();
    chk("run_start", start, 1);
    chk("run_pc0", pc, 0);
    chk("run_instr0", data, mem_m[0]);
    chk("run_busy", busy, 1);
    chk("run_err_clr", err, 0);
    chk("run_halt_clr", halt, 0);
    for (int p = 0; p <= last; p++) begin
      // Issue cycle: a completion or run request here must be ignored.
      pcincr = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) run = 1'b1;
      if (fixed_delay > 0) d = fixed_delay;
      else if ($urandom_range(3, 0) == 0) d = TO;
      else d = $urandom_range(TO, 1);
      for (int w = 1; w <= d && w <= TO; w++) begin
        tick();
        chk("wait_start", start, 0);
        chk("wait_busy", busy, 1);
        chk("wait_pc", pc, p);
        chk("wait_instr", data, mem_m[p]);
        if (p == rst_pc && w == 1) begin
          rst    = 1'b1;
          pcincr = 1'b1;
          run    = 1'b1;
          tick();
          chk("rst_start", start, 0);
          chk("rst_busy", busy, 0);
          chk("rst_halt", halt, 0);
          chk("rst_err", err, 0);
          chk("rst_pc", pc, 0);
          chk("rst_instr", data, 0);
          return;
        end
        pcincr = (w == d);
        if (p == 0 && w == 1 && drop_addr >= 0) begin
          load_en    = 1'b1;
          load_addr  = drop_addr[AW-1:0];
          load_instr = ~mem_m[drop_addr];
        end else if ($urandom_range(2, 0) == 0) begin
          load_en    = 1'b1;
          load_addr  = AW'($urandom);
          load_instr = 3'($urandom);
        end
        if ($urandom_range(3, 0) == 0) run = 1'b1;
      end
      tick();
      if (d > TO) begin
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_halt", halt, 0);
        chk("to_pc", pc, p);
        chk("to_instr", data, mem_m[p]);
        pcincr = 1'b1;
        tick();
        chk("to_hold_err", err, 1);
        chk("to_hold_pc", pc, p);
        chk("to_hold_start", start, 0);
        return;
      end else if (p == last) begin
        chk("done_halt", halt, 1);
        chk("done_busy", busy, 0);
        chk("done_start", start, 0);
        chk("done_pc", pc, p);
        chk("done_instr", data, mem_m[p]);
      end else begin
        chk("next_start", start, 1);
        chk("next_busy", busy, 1);
        chk("next_pc", pc, p + 1);
        chk("next_instr", data, mem_m[p + 1]);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    load_en    = 1'b0;
    load_addr  = '0;
    load_instr = '0;
    run        = 1'b1;
    last_addr  = '1;
    pcincr     = 1'b1;
    tick();
    chk("reset_start", start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_halt", halt, 0);
    chk("reset_err", err, 0);
    chk("reset_pc", pc, 0);
    chk("reset_instr", data, 0);

    for (int a = 0; a < 16; a++) load_mem(a, 3'($urandom));
    load_mem(0, 3'b001);
    load_mem(1, 3'b010);
    load_mem(2, 3'b011);

    // Three-instruction program, completion three cycles after each start.
    run_prog(2, 3, -1, -1, 1'b0);
    pcincr = 1'b1;
    tick();
    chk("done_hold_pc", pc, 2);
    chk("done_hold_halt", halt, 1);
    chk("done_hold_start", start, 0);
    // A write while done is accepted, but the held instruction does not change.
    load_mem(2, 3'b110);
    chk("done_hold_instr", data, 3'b011);

    // Core never completes, then recover with a new run.
    run_prog(0, TO + 1, -1, -1, 1'b0);
    run_prog(0, 0, -1, -1, 1'b0);

    // Completion exactly on the last allowed wait cycle.
    run_prog(3, TO, -1, -1, 1'b0);

    // Write to address 5 while busy must be dropped.
    run_prog(7, 0, 5, -1, 1'b0);

    // Reset mid-program at pc 3, then the program must still be intact.
    run_prog(7, 2, -1, 3, 1'b0);
    run_prog(7, 0, -1, -1, 1'b0);

    // Write and run in the same cycle.
    run_prog(2, 0, -1, -1, 1'b1);

    // Full-depth program, immediate completions, no wrap.
    run_prog(15, 1, -1, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pcincr = 1'b1;
      tick();
      chk("nowrap_start", start, 0);
      chk("nowrap_pc", pc, 15);
      chk("nowrap_halt", halt, 1);
    end

    // Randomized runs with occasional program updates in between.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(1, 0) == 1) load_mem($urandom_range(15, 0), 3'($urandom));
      run_prog($urandom_range(15, 0), 0, -1, -1, 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
